// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register slave: bus FSM states,
// register offsets and field widths.
package apb_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int WAIT_W = 4;
  localparam int CNT_W  = 16;

  localparam logic [7:0] CTRL_OFF     = 8'h00;
  localparam logic [7:0] STATUS_OFF   = 8'h04;
  localparam logic [7:0] SCRATCH0_OFF = 8'h08;
  localparam logic [7:0] SCRATCH1_OFF = 8'h0C;
  localparam logic [7:0] SCRATCH2_OFF = 8'h10;
  localparam logic [7:0] SCRATCH3_OFF = 8'h14;

endpackage

// File: rtl/apb_wait_timer.sv
// Down-counter that stretches the APB access phase by a programmable
// number of wait cycles.
module apb_wait_timer
  import apb_slave_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              enable,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regs.sv
// APB register slave with CTRL, STATUS counters and four scratch registers.
// Define APB_SLVERR_EN to compile in Pslverr responses for bad accesses.
module apb_slave_regs
  import apb_slave_pkg::*;
#(
  parameter logic [31:0]       BASE_ADDR  = 32'h0000_0000,
  parameter logic [WAIT_W-1:0] RESET_WAIT = 4'd0
) (
  input  logic        Pclk,
  input  logic        Preset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  apb_state_e        state_q;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       scratch_q [4];
  logic [31:0]       scratch_d [4];
  logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;
  logic [CNT_W-1:0]  rdCnt_q, rdCnt_d;

  logic        timerZero;
  logic [7:0]  offset;
  logic        isCtrl, isStatus, isScr, mapped;
  logic [1:0]  scrIdx;
  logic [31:0] regData;
  logic        wrCommit, rdDone, wrCount;

  assign offset   = Paddr[7:0];
  assign isCtrl   = (offset == CTRL_OFF);
  assign isStatus = (offset == STATUS_OFF);
  assign isScr    = offset inside {SCRATCH0_OFF, SCRATCH1_OFF, SCRATCH2_OFF, SCRATCH3_OFF};
  assign mapped   = (Paddr[31:8] == BASE_ADDR[31:8]) && (Paddr[1:0] == 2'b00) &&
                    (isCtrl || isStatus || isScr);
  // Maps offsets 0x08/0x0C/0x10/0x14 onto scratch indices 0..3.
  assign scrIdx   = {~offset[3], offset[2]};

  apb_wait_timer u_wait_timer (
    .clk_i   (Pclk),
    .reset_i (Preset),
    .load    (state_q == SETUP),
    .load_val(wait_q),
    .enable  (state_q == ACCESS),
    .zero    (timerZero)
  );

  assign Pready   = !Preset && (state_q == ACCESS) && Psel && Penable && timerZero;
  assign wrCommit = Pready && Pwrite;
  assign rdDone   = Pready && !Pwrite && mapped;

`ifdef APB_SLVERR_EN
  assign Pslverr = Pready && (!mapped || (Pwrite && isStatus));
  assign wrCount = wrCommit && mapped && !isStatus;
`else
  assign Pslverr = 1'b0;
  assign wrCount = wrCommit && mapped;
`endif

  always_comb begin
    regData = '0;
    if (isCtrl) begin
      regData = {{(32-WAIT_W){1'b0}}, wait_q};
    end else if (isStatus) begin
      regData = {rdCnt_q, wrCnt_q};
    end else if (isScr) begin
      regData = scratch_q[scrIdx];
    end
  end

  assign Prdata = (Pready && mapped) ? regData : '0;

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (Psel && !Penable) state_q <= SETUP;
        SETUP:   state_q <= ACCESS;
        ACCESS:  if (!Psel || Pready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // STATUS is read-only, so only CTRL and scratch writes change storage.
  always_comb begin
    wait_d    = wait_q;
    scratch_d = scratch_q;
    wrCnt_d   = wrCnt_q;
    rdCnt_d   = rdCnt_q;
    if (wrCommit && mapped && isCtrl) wait_d = Pwdata[WAIT_W-1:0];
    if (wrCommit && mapped && isScr) scratch_d[scrIdx] = Pwdata;
    if (wrCount && (wrCnt_q != '1)) wrCnt_d = wrCnt_q + CNT_W'(1);
    if (rdDone && (rdCnt_q != '1)) rdCnt_d = rdCnt_q + CNT_W'(1);
  end

  always_ff @(posedge Pclk) begin
    if (Preset) begin
      wait_q    <= RESET_WAIT;
      scratch_q <= '{default: '0};
      wrCnt_q   <= '0;
      rdCnt_q   <= '0;
    end else begin
      wait_q    <= wait_d;
      scratch_q <= scratch_d;
      wrCnt_q   <= wrCnt_d;
      rdCnt_q   <= rdCnt_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard testbench for apb_slave_regs: the driver queues the expected
// response of each transfer and a negedge monitor checks it on Pready.
module tb_apb_slave_regs;

`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic        Pclk = 1'b0;
  logic        Preset = 1'b1;
  logic        Psel = 1'b0;
  logic        Penable = 1'b0;
  logic        Pwrite = 1'b0;
  logic [31:0] Paddr = '0;
  logic [31:0] Pwdata = '0;
  logic [31:0] Prdata;
  logic        Pready;
  logic        Pslverr;

  int checks = 0;
  int errors = 0;
  int waitCnt = 0;

  typedef struct {
    logic [31:0] data;
    logic        chkData;
    logic        err;
    int          waits;
  } exp_t;

  exp_t  expQ [$];
  string nameQ [$];

  apb_slave_regs dut (
    .Pclk   (Pclk),
    .Preset (Preset),
    .Psel   (Psel),
    .Penable(Penable),
    .Pwrite (Pwrite),
    .Paddr  (Paddr),
    .Pwdata (Pwdata),
    .Prdata (Prdata),
    .Pready (Pready),
    .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Wait count covers every Penable-high cycle with Pready low, which is
  // the SETUP-state cycle plus CTRL.WAIT cycles in ACCESS.
  always @(negedge Pclk) begin
    exp_t  e;
    string n;
    if (!Psel || Preset) begin
      waitCnt = 0;
    end else if (Penable && !Pready) begin
      waitCnt++;
    end
    if (Pready) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_pready actual=1 required=0 addr=%h", Paddr);
      end else begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput({n, "_waits"}, 32'(waitCnt), 32'(e.waits));
        checkOutput({n, "_pslverr"}, {31'b0, Pslverr}, {31'b0, e.err});
        if (e.chkData) checkOutput({n, "_prdata"}, Prdata, e.data);
      end
      waitCnt = 0;
    end
  end

  // Called #1 after a rising edge; returns #1 after the completing edge so
  // consecutive calls form back-to-back transfers.
  task automatic applyStimulus(input string name, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic chkData,
                               input logic [31:0] expData, input logic expErr,
                               input int expWaits);
    int guard;
    expQ.push_back('{data: expData, chkData: chkData, err: expErr, waits: expWaits});
    nameQ.push_back(name);
    Psel = 1'b1;
    Penable = 1'b0;
    Pwrite = wr;
    Paddr = addr;
    Pwdata = wdata;
    @(posedge Pclk);
    #1 Penable = 1'b1;
    guard = 0;
    do begin
      @(negedge Pclk);
      guard++;
    end while (!Pready && guard < 64);
    if (!Pready) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=no_pready required=pready", name);
    end
    @(posedge Pclk);
    #1;
    Psel = 1'b0;
    Penable = 1'b0;
  endtask

  task automatic doWrite(input string name, input logic [31:0] addr, input logic [31:0] data,
                         input logic expErr, input int expWaits);
    applyStimulus(name, 1'b1, addr, data, 1'b0, '0, expErr, expWaits);
  endtask

  task automatic doRead(input string name, input logic [31:0] addr, input logic [31:0] expData,
                        input logic expErr, input int expWaits);
    applyStimulus(name, 1'b0, addr, '0, 1'b1, expData, expErr, expWaits);
  endtask

  initial begin
    logic [15:0] wrExp;
    $display("[TB] start, APB_SLVERR_EN=%0d", SLV);
    repeat (3) @(posedge Pclk);
    #1;
    checkOutput("reset_pready", {31'b0, Pready}, 32'h0);
    checkOutput("reset_prdata", Prdata, 32'h0);
    checkOutput("reset_pslverr", {31'b0, Pslverr}, 32'h0);
    Preset = 1'b0;
    @(posedge Pclk);
    #1;

    // WAIT=0 basic write/read and counters
    doWrite("wr_scr0", 32'h08, 32'hA5A5_0001, 1'b0, 1);
    doRead("rd_scr0", 32'h08, 32'hA5A5_0001, 1'b0, 1);
    doRead("rd_status1", 32'h04, 32'h0001_0001, 1'b0, 1);

    // CTRL write takes effect from the next transfer
    doWrite("wr_ctrl3", 32'h00, 32'hFFFF_FFF3, 1'b0, 1);
    doRead("rd_ctrl3", 32'h00, 32'h0000_0003, 1'b0, 4);
    doRead("rd_scr1", 32'h0C, 32'h0, 1'b0, 4);

    // Unmapped and STATUS writes
    doWrite("wr_unmapped", 32'h40, 32'h0000_1234, SLV, 4);
    doWrite("wr_status", 32'h04, 32'hFFFF_FFFF, SLV, 4);
    doRead("rd_status2", 32'h04, {16'd4, SLV ? 16'd2 : 16'd3}, 1'b0, 4);

    // Unmapped reads return 0 and are not counted
    doRead("rd_unmapped", 32'h44, 32'h0, SLV, 4);
    doRead("rd_misaligned", 32'h0A, 32'h0, SLV, 4);
    doRead("rd_otherbase", 32'h108, 32'h0, SLV, 4);

    doWrite("wr_ctrl5", 32'h00, 32'h0000_0005, 1'b0, 4);

    // Abort a write after two ACCESS cycles
    Psel = 1'b1;
    Penable = 1'b0;
    Pwrite = 1'b1;
    Paddr = 32'h10;
    Pwdata = 32'hDEAD_BEEF;
    @(posedge Pclk);
    #1 Penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Pclk);
      checkOutput("abort_pready", {31'b0, Pready}, 32'h0);
    end
    Psel = 1'b0;
    Penable = 1'b0;
    @(posedge Pclk);
    #1;
    doRead("rd_scr2_abort", 32'h10, 32'h0, 1'b0, 6);
    doRead("rd_status3", 32'h04, {16'd6, SLV ? 16'd3 : 16'd4}, 1'b0, 6);

    doWrite("wr_ctrl0", 32'h00, 32'h0, 1'b0, 6);
    doWrite("wr_scr3", 32'h14, 32'h0BAD_F00D, 1'b0, 1);
    doRead("rd_scr3", 32'h14, 32'h0BAD_F00D, 1'b0, 1);

    // RD_CNT saturation
    wrExp = SLV ? 16'd5 : 16'd6;
    force dut.rdCnt_q = 16'hFFFE;
    @(posedge Pclk);
    #1 release dut.rdCnt_q;
    doRead("rd_sat1", 32'h04, {16'hFFFE, wrExp}, 1'b0, 1);
    doRead("rd_sat2", 32'h04, {16'hFFFF, wrExp}, 1'b0, 1);
    doRead("rd_sat3", 32'h04, {16'hFFFF, wrExp}, 1'b0, 1);

    // Reset in the middle of a wait-stretched write
    doWrite("wr_ctrl4", 32'h00, 32'h0000_0004, 1'b0, 1);
    Psel = 1'b1;
    Penable = 1'b0;
    Pwrite = 1'b1;
    Paddr = 32'h08;
    Pwdata = 32'h1111_1111;
    @(posedge Pclk);
    #1 Penable = 1'b1;
    repeat (3) @(negedge Pclk);
    Preset = 1'b1;
    #1;
    checkOutput("midrst_pready", {31'b0, Pready}, 32'h0);
    checkOutput("midrst_prdata", Prdata, 32'h0);
    @(posedge Pclk);
    #1;
    checkOutput("midrst_pready2", {31'b0, Pready}, 32'h0);
    checkOutput("midrst_pslverr", {31'b0, Pslverr}, 32'h0);
    @(posedge Pclk);
    #1;
    Preset = 1'b0;
    Psel = 1'b0;
    Penable = 1'b0;
    @(posedge Pclk);
    #1;
    doRead("rd_status_rst", 32'h04, 32'h0, 1'b0, 1);
    doRead("rd_ctrl_rst", 32'h00, 32'h0, 1'b0, 1);
    doRead("rd_scr0_rst", 32'h08, 32'h0, 1'b0, 1);
    doRead("rd_scr3_rst", 32'h14, 32'h0, 1'b0, 1);

    repeat (3) @(posedge Pclk);
    #1;
    checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
